// File: rtl/meteo_arb_pkg.sv
// Shared types and constants for the meteo I2C byte-interface arbiter.
package meteo_arb_pkg;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANTED = 2'd1,
    ST_BUSY    = 2'd2
  } arb_state_e;

  // One byte command as presented by a requester to the controller.
  typedef struct packed {
    logic              rdwr;
    logic              last;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] txd;
  } byte_cmd_t;

  // Ceiling log2, used to size the requester index / round-robin pointer.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = unsigned'(i + 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/meteo_i2c_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick
  import meteo_arb_pkg::*;
#(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned PTR_W = clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt_c,
  output logic [PTR_W-1:0] idx_c,
  output logic             valid_c
);

  logic [PTR_W-1:0] cand;

  // Scan from the farthest candidate down so the one nearest ptr wins.
  always_comb begin
    gnt_c   = '0;
    idx_c   = '0;
    valid_c = 1'b0;
    cand    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = PTR_W'((32'(ptr) + unsigned'(k)) % NREQ);
      if (req[cand]) begin
        gnt_c       = '0;
        gnt_c[cand] = 1'b1;
        idx_c       = cand;
        valid_c     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/meteo_i2c_arbiter.sv
// Round-robin arbiter sharing one bme280_i2c_ctrl byte interface between NREQ
// requesters. A grant covers a whole transfer (up to the byte flagged Last);
// one shared counter provides both the idle-grant and the per-byte timeout.
module meteo_i2c_arbiter
  import meteo_arb_pkg::*;
#(
  parameter int unsigned NREQ      = 2,
  parameter int unsigned TO_CYCLES = 4096,
  parameter int unsigned IDLE_TO   = 255
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic [NREQ-1:0]        Req,
  input  logic [NREQ-1:0]        Start,
  input  logic [NREQ-1:0]        Rdwr,
  input  logic [NREQ-1:0]        Last,
  input  logic [NREQ*ADDR_W-1:0] Addr,
  input  logic [NREQ*DATA_W-1:0] Txd,
  output logic [NREQ-1:0]        Gnt,
  output logic [NREQ-1:0]        Done,
  output logic [DATA_W-1:0]      Rxd,
  output logic                   Timeout,
  output logic                   I2C_start,
  output logic                   I2C_rdwr,
  output logic                   I2C_last,
  output logic [ADDR_W-1:0]      I2C_addr,
  output logic [DATA_W-1:0]      I2C_txd,
  input  logic [DATA_W-1:0]      I2C_rxd,
  input  logic                   I2C_done
);

  localparam int unsigned      PTR_W    = clog2(NREQ);
  localparam logic [CNT_W-1:0] BYTE_LIM = CNT_W'(TO_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLE_LIM = CNT_W'(IDLE_TO - 1);

  arb_state_e       state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [PTR_W-1:0] gidx_q, gidx_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [NREQ-1:0]  pick_gnt;
  logic [PTR_W-1:0] pick_idx;
  logic             pick_valid;

  byte_cmd_t        cmd_g;
  logic             start_g;
  logic             req_g;
  logic             rel_c;
  logic [PTR_W-1:0] ptr_inc;

  rr_pick #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req     (Req),
    .ptr     (ptr_q),
    .gnt_c   (pick_gnt),
    .idx_c   (pick_idx),
    .valid_c (pick_valid)
  );

  // Select the granted requester's command, start pulse and request level.
  always_comb begin
    cmd_g   = '0;
    start_g = 1'b0;
    req_g   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gidx_q == PTR_W'(i)) begin
        cmd_g.rdwr = Rdwr[i];
        cmd_g.last = Last[i];
        cmd_g.addr = Addr[i*ADDR_W +: ADDR_W];
        cmd_g.txd  = Txd[i*DATA_W +: DATA_W];
        start_g    = Start[i];
        req_g      = Req[i];
      end
    end
  end

  // Next round-robin position: the requester after the one being released.
  always_comb begin
    ptr_inc = gidx_q + PTR_W'(1);
    if (gidx_q == PTR_W'(NREQ - 1)) ptr_inc = '0;
  end

  // Arbitration FSM: next state, counter and controller-facing outputs.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gidx_d    = gidx_q;
    ptr_d     = ptr_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    rel_c     = 1'b0;
    Timeout   = 1'b0;
    Done      = '0;
    I2C_start = 1'b0;
    I2C_rdwr  = 1'b0;
    I2C_last  = 1'b0;
    I2C_addr  = '0;
    I2C_txd   = '0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (pick_valid) begin
          gnt_d   = pick_gnt;
          gidx_d  = pick_idx;
          state_d = ST_GRANTED;
        end
      end

      ST_GRANTED: begin
        I2C_start = start_g;
        I2C_rdwr  = cmd_g.rdwr;
        I2C_last  = cmd_g.last;
        I2C_addr  = cmd_g.addr;
        I2C_txd   = cmd_g.txd;
        if (start_g) begin
          last_d  = cmd_g.last;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end else if (!req_g) begin
          rel_c = 1'b1;
        end else if (cnt_q >= IDLE_LIM) begin
          rel_c   = 1'b1;
          Timeout = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_BUSY: begin
        // Requester holds its command stable until Done; keep mirroring it.
        I2C_rdwr = cmd_g.rdwr;
        I2C_last = cmd_g.last;
        I2C_addr = cmd_g.addr;
        I2C_txd  = cmd_g.txd;
        Done     = gnt_q & {NREQ{I2C_done}};
        if (I2C_done) begin
          cnt_d = '0;
          if (last_q) rel_c = 1'b1;
          else        state_d = ST_GRANTED;
        end else if (cnt_q >= BYTE_LIM) begin
          rel_c   = 1'b1;
          Timeout = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Release always passes through IDLE so grants are separated by a cycle.
    if (rel_c) begin
      state_d = ST_IDLE;
      gnt_d   = '0;
      ptr_d   = ptr_inc;
      cnt_d   = '0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Gnt = gnt_q;
  assign Rxd = I2C_rxd;

endmodule

// File: tb/tb_meteo_i2c_arbiter.sv
// Self-checking bench for meteo_i2c_arbiter (NREQ=2, TO_CYCLES=16, IDLE_TO=8).
module tb_meteo_i2c_arbiter;

  localparam int unsigned NREQ = 2;
  localparam int unsigned TO   = 16;
  localparam int unsigned ITO  = 8;

  logic              Clk = 1'b0;
  logic              Rst;
  logic [NREQ-1:0]   Req, Start, Rdwr, Last;
  logic [NREQ*7-1:0] Addr;
  logic [NREQ*8-1:0] Txd;
  logic [NREQ-1:0]   Gnt, Done;
  logic [7:0]        Rxd;
  logic              Timeout;
  logic              I2C_start, I2C_rdwr, I2C_last;
  logic [6:0]        I2C_addr;
  logic [7:0]        I2C_txd;
  logic [7:0]        I2C_rxd;
  logic              I2C_done;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  typedef struct {
    logic [1:0] done;
    logic [7:0] rxd;
  } exp_t;
  exp_t exp_q[$];

  meteo_i2c_arbiter #(.NREQ(NREQ), .TO_CYCLES(TO), .IDLE_TO(ITO)) dut (
    .Clk(Clk), .Rst(Rst), .Req(Req), .Start(Start), .Rdwr(Rdwr), .Last(Last),
    .Addr(Addr), .Txd(Txd), .Gnt(Gnt), .Done(Done), .Rxd(Rxd), .Timeout(Timeout),
    .I2C_start(I2C_start), .I2C_rdwr(I2C_rdwr), .I2C_last(I2C_last),
    .I2C_addr(I2C_addr), .I2C_txd(I2C_txd), .I2C_rxd(I2C_rxd), .I2C_done(I2C_done)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no summary, want completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    Start = '0; Rdwr = '0; Last = '0; Addr = '0; Txd = '0;
    I2C_done = 1'b0; I2C_rxd = 8'h00;
  endtask

  // Drive one byte for requester r from a GRANTED cycle; controller answers dly cycles later.
  task automatic run_byte(input int r, input logic rdwr, input logic last,
                          input logic [6:0] addr, input logic [7:0] txd, input int dly,
                          input logic [7:0] rxd, output logic st_obs, output logic [7:0] txd_obs,
                          output logic [1:0] early, output logic [1:0] done_obs,
                          output logic [7:0] rxd_obs);
    early = '0;
    Start = '0; Start[r] = 1'b1; Rdwr[r] = rdwr; Last[r] = last;
    Addr[r*7 +: 7] = addr; Txd[r*8 +: 8] = txd;
    settle();
    st_obs = I2C_start; txd_obs = I2C_txd;
    for (int k = 1; k < dly; k++) begin
      tick(); Start = '0; settle(); early |= Done;
    end
    tick(); Start = '0; I2C_done = 1'b1; I2C_rxd = rxd;
    settle();
    done_obs = Done; rxd_obs = Rxd;
    tick(); I2C_done = 1'b0; I2C_rxd = 8'h00;
  endtask

  task automatic test_reset();
    Rst = 1'b1; Req = 2'b11; idle_inputs();
    tick(); tick(); settle();
    n_vec++;
    if ({Gnt, Done, Timeout, I2C_start, I2C_rdwr, I2C_last, I2C_addr, I2C_txd} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got gnt=%b done=%b to=%b st=%b addr=%h txd=%h, want all zero",
               Gnt, Done, Timeout, I2C_start, I2C_addr, I2C_txd);
    end
    tick(); Rst = 1'b0; Req = 2'b00; settle();
    n_vec++;
    if (Gnt !== 2'b00) begin
      n_err++; $display("FAIL reset_no_grant: got gnt=%b want 00", Gnt);
    end
    tick();
  endtask

  // Three-byte write from requester 0, then confirm ptr moved to 1.
  task automatic test_single_transfer();
    logic st; logic [7:0] tx, rx; logic [1:0] early, dn; exp_t e;
    Req = 2'b01; settle();
    n_vec++;
    if (Gnt !== 2'b00) begin n_err++; $display("FAIL t1_latency: got gnt=%b want 00", Gnt); end
    tick(); settle();
    n_vec++;
    if (Gnt !== 2'b01) begin n_err++; $display("FAIL t1_grant: got gnt=%b want 01", Gnt); end
    for (int b = 0; b < 3; b++) begin
      e.done = 2'b01; e.rxd = 8'(8'h3C + b); exp_q.push_back(e);
      run_byte(0, 1'b0, (b == 2), 7'h76, 8'(8'h10 + b), 12, 8'(8'h3C + b), st, tx, early, dn, rx);
      e = exp_q.pop_front();
      n_vec++;
      if (st !== 1'b1 || tx !== 8'(8'h10 + b) || early !== 2'b00) begin
        n_err++;
        $display("FAIL t1_byte%0d_start: got st=%b txd=%h early=%b want st=1 txd=%h early=00",
                 b, st, tx, early, 8'(8'h10 + b));
      end
      n_vec++;
      if (dn !== e.done || rx !== e.rxd) begin
        n_err++;
        $display("FAIL t1_byte%0d_done: got done=%b rxd=%h want done=%b rxd=%h", b, dn, rx, e.done, e.rxd);
      end
      settle();
      n_vec++;
      if (Gnt !== ((b == 2) ? 2'b00 : 2'b01)) begin
        n_err++; $display("FAIL t1_byte%0d_gnt_after: got gnt=%b want %b", b, Gnt, (b == 2) ? 2'b00 : 2'b01);
      end
    end
    Req = 2'b11;
    tick(); settle();
    n_vec++;
    if (Gnt !== 2'b10) begin n_err++; $display("FAIL t1_ptr_next: got gnt=%b want 10", Gnt); end
    Req = 2'b00;
    tick(); settle();
    n_vec++;
    if (Gnt !== 2'b00) begin n_err++; $display("FAIL t1_drop_release: got gnt=%b want 00", Gnt); end
  endtask

  // Both requesting: grants alternate with one idle cycle; A5 only on the granted Done.
  task automatic test_round_robin();
    logic st; logic [7:0] tx, rx; logic [1:0] early, dn; exp_t e; logic [1:0] eg;
    eg = 2'b01;
    Req = 2'b11;
    for (int n = 0; n < 4; n++) begin
      tick(); settle();
      n_vec++;
      if (Gnt !== eg) begin n_err++; $display("FAIL t2_grant%0d: got gnt=%b want %b", n, Gnt, eg); end
      e.done = eg; e.rxd = 8'hA5; exp_q.push_back(e);
      run_byte(eg[1] ? 1 : 0, 1'b1, 1'b1, 7'h77, 8'h00, 3, 8'hA5, st, tx, early, dn, rx);
      e = exp_q.pop_front();
      n_vec++;
      if (dn !== e.done || rx !== e.rxd || early !== 2'b00) begin
        n_err++;
        $display("FAIL t2_done%0d: got done=%b rxd=%h early=%b want done=%b rxd=%h early=00",
                 n, dn, rx, early, e.done, e.rxd);
      end
      settle();
      n_vec++;
      if (Gnt !== 2'b00) begin n_err++; $display("FAIL t2_gap%0d: got gnt=%b want 00", n, Gnt); end
      eg = {eg[0], eg[1]};
    end
    Req = 2'b00;
    tick();
  endtask

  // Start pulses from the non-granted requester must never reach the controller.
  task automatic test_foreign_start();
    exp_t e;
    Req = 2'b01;
    tick(); settle();
    n_vec++;
    if (Gnt !== 2'b01) begin n_err++; $display("FAIL t3_grant: got gnt=%b want 01", Gnt); end
    Req = 2'b11; Start = 2'b10; settle();
    n_vec++;
    if (I2C_start !== 1'b0) begin n_err++; $display("FAIL t3_foreign_granted: got start=%b want 0", I2C_start); end
    tick(); Start = 2'b01; Rdwr = 2'b00; Last = 2'b01; Addr = 14'h0076; settle();
    n_vec++;
    if (I2C_start !== 1'b1 || I2C_addr !== 7'h76) begin
      n_err++; $display("FAIL t3_own_start: got start=%b addr=%h want 1 76", I2C_start, I2C_addr);
    end
    e.done = 2'b01; e.rxd = 8'h5A; exp_q.push_back(e);
    tick(); Start = 2'b10; settle();
    n_vec++;
    if (I2C_start !== 1'b0 || Done !== 2'b00) begin
      n_err++; $display("FAIL t3_foreign_busy: got start=%b done=%b want 0 00", I2C_start, Done);
    end
    tick(); Start = 2'b00;
    tick(); I2C_done = 1'b1; I2C_rxd = 8'h5A; Req = 2'b00; settle();
    e = exp_q.pop_front();
    n_vec++;
    if (Done !== e.done || Rxd !== e.rxd) begin
      n_err++; $display("FAIL t3_done: got done=%b rxd=%h want %b %h", Done, Rxd, e.done, e.rxd);
    end
    tick(); I2C_done = 1'b0; I2C_rxd = 8'h00; Last = 2'b00; settle();
    n_vec++;
    if (Gnt !== 2'b00) begin n_err++; $display("FAIL t3_release: got gnt=%b want 00", Gnt); end
  endtask

  // Byte never completes: Timeout 16 cycles after Start, late I2C_done ignored.
  task automatic test_byte_timeout();
    logic early_to; logic [1:0] early_dn;
    early_to = 1'b0; early_dn = 2'b00;
    Req = 2'b10;
    tick(); settle();
    n_vec++;
    if (Gnt !== 2'b10) begin n_err++; $display("FAIL t4_grant: got gnt=%b want 10", Gnt); end
    Start = 2'b10; Last = 2'b00; Rdwr = 2'b00; settle();
    for (int k = 1; k < 16; k++) begin
      tick(); Start = 2'b00; settle();
      early_to |= Timeout; early_dn |= Done;
    end
    n_vec++;
    if (early_to !== 1'b0 || early_dn !== 2'b00) begin
      n_err++; $display("FAIL t4_early: got to=%b done=%b want 0 00", early_to, early_dn);
    end
    tick(); settle();
    n_vec++;
    if ({Timeout, Gnt, Done} !== 5'b1_10_00) begin
      n_err++; $display("FAIL t4_expiry: got to=%b gnt=%b done=%b want 1 10 00", Timeout, Gnt, Done);
    end
    Req = 2'b00;
    tick(); settle();
    n_vec++;
    if ({Gnt, Timeout} !== 3'b000) begin
      n_err++; $display("FAIL t4_release: got gnt=%b to=%b want 00 0", Gnt, Timeout);
    end
    for (int k = 0; k < 4; k++) tick();
    I2C_done = 1'b1; I2C_rxd = 8'hFF; settle();
    n_vec++;
    if (Done !== 2'b00) begin n_err++; $display("FAIL t4_late_done: got done=%b want 00", Done); end
    tick(); I2C_done = 1'b0; I2C_rxd = 8'h00; settle();
    n_vec++;
    if (Gnt !== 2'b00) begin n_err++; $display("FAIL t4_stay_idle: got gnt=%b want 00", Gnt); end
  endtask

  // Granted requester never starts: idle timeout after 8 cycles, grant moves on.
  task automatic test_idle_timeout();
    logic early_to;
    Req = 2'b11;
    tick(); settle();
    n_vec++;
    if (Gnt !== 2'b01) begin n_err++; $display("FAIL t5_grant: got gnt=%b want 01", Gnt); end
    early_to = Timeout;
    for (int k = 1; k < 7; k++) begin
      tick(); settle(); early_to |= Timeout;
    end
    n_vec++;
    if (early_to !== 1'b0) begin n_err++; $display("FAIL t5_early: got to=%b want 0", early_to); end
    tick(); settle();
    n_vec++;
    if ({Timeout, Gnt} !== 3'b1_01) begin
      n_err++; $display("FAIL t5_expiry: got to=%b gnt=%b want 1 01", Timeout, Gnt);
    end
    tick(); settle();
    n_vec++;
    if ({Timeout, Gnt} !== 3'b0_00) begin
      n_err++; $display("FAIL t5_release: got to=%b gnt=%b want 0 00", Timeout, Gnt);
    end
    tick(); settle();
    n_vec++;
    if (Gnt !== 2'b10) begin n_err++; $display("FAIL t5_next: got gnt=%b want 10", Gnt); end
    Req = 2'b00;
    tick(); settle();
  endtask

  // Same requester twice in a row still sees one idle cycle between grants.
  task automatic test_back_to_back();
    logic st; logic [7:0] tx, rx; logic [1:0] early, dn; exp_t e;
    Req = 2'b01;
    for (int n = 0; n < 2; n++) begin
      tick(); settle();
      n_vec++;
      if (Gnt !== 2'b01) begin n_err++; $display("FAIL b2b_grant%0d: got gnt=%b want 01", n, Gnt); end
      e.done = 2'b01; e.rxd = 8'(8'h60 + n); exp_q.push_back(e);
      run_byte(0, 1'b1, 1'b1, 7'h76, 8'h00, 2, 8'(8'h60 + n), st, tx, early, dn, rx);
      e = exp_q.pop_front();
      n_vec++;
      if (dn !== e.done || rx !== e.rxd) begin
        n_err++; $display("FAIL b2b_done%0d: got done=%b rxd=%h want %b %h", n, dn, rx, e.done, e.rxd);
      end
      settle();
      n_vec++;
      if (Gnt !== 2'b00) begin n_err++; $display("FAIL b2b_gap%0d: got gnt=%b want 00", n, Gnt); end
    end
    Req = 2'b00;
    tick();
  endtask

  // Reset in the middle of byte 2 of 3: everything back to reset values, ptr=0.
  task automatic test_reset_midtransfer();
    logic st; logic [7:0] tx, rx; logic [1:0] early, dn; exp_t e;
    Req = 2'b10;
    tick(); settle();
    n_vec++;
    if (Gnt !== 2'b10) begin n_err++; $display("FAIL t6_grant: got gnt=%b want 10", Gnt); end
    e.done = 2'b10; e.rxd = 8'hC3; exp_q.push_back(e);
    run_byte(1, 1'b0, 1'b0, 7'h76, 8'hB1, 4, 8'hC3, st, tx, early, dn, rx);
    e = exp_q.pop_front();
    n_vec++;
    if (dn !== e.done || rx !== e.rxd) begin
      n_err++; $display("FAIL t6_byte1: got done=%b rxd=%h want %b %h", dn, rx, e.done, e.rxd);
    end
    Start = 2'b10; Txd[15:8] = 8'hB2; settle();
    tick(); Start = 2'b00;
    tick(); Rst = 1'b1;
    tick(); Rst = 1'b0; Req = 2'b11; settle();
    n_vec++;
    if ({Gnt, I2C_start, Done, Timeout, I2C_addr, I2C_txd} !== '0) begin
      n_err++;
      $display("FAIL t6_after_reset: got gnt=%b st=%b done=%b to=%b addr=%h txd=%h want all zero",
               Gnt, I2C_start, Done, Timeout, I2C_addr, I2C_txd);
    end
    tick(); settle();
    n_vec++;
    if (Gnt !== 2'b01) begin n_err++; $display("FAIL t6_ptr_reset: got gnt=%b want 01", Gnt); end
    Req = 2'b00;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_single_transfer();
    test_round_robin();
    test_foreign_start();
    test_byte_timeout();
    test_idle_timeout();
    test_back_to_back();
    test_reset_midtransfer();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
